// File: rtl/pb_gesture_decoder.sv
// rtl/pb_gesture_decoder.sv - click / double-click / long-press classifier for a debounced push button
// Optional auto-repeat while held long: define PB_GESTURE_AUTO_REPEAT_EN.
module pb_gesture_decoder #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int GAP_CYCLES    = 25_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic PB_pressed_status,
    input  logic PB_pressed_pulse,
    input  logic PB_released_pulse,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic busy
);

    localparam int MAX_LG = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int MAX_C  = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
    localparam int TW     = $clog2(MAX_C) + 1;

    // Registered event pulses land one cycle after the decision, so the
    // long/gap decisions are taken one count early.
    localparam logic [TW-1:0] LONG_LIM = TW'(LONG_CYCLES - 2);
    localparam logic [TW-1:0] GAP_LIM  = TW'(GAP_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   timer;
    logic            timer_clr;
    logic            press_ev;
    logic            release_ev;
    logic            single_next;
    logic            double_next;
    logic            long_next;

    // Simultaneous press and release edges cancel out.
    assign press_ev   = PB_pressed_pulse & ~PB_released_pulse;
    assign release_ev = PB_released_pulse & ~PB_pressed_pulse;

`ifdef PB_GESTURE_AUTO_REPEAT_EN
    localparam logic [TW-1:0] REP_LIM = TW'(REPEAT_CYCLES - 1);
    logic repeat_next;
`endif

    always_comb begin
        state_next  = state;
        single_next = 1'b0;
        double_next = 1'b0;
        long_next   = 1'b0;
`ifdef PB_GESTURE_AUTO_REPEAT_EN
        repeat_next = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (press_ev)
                    state_next = PRESS1;
            end
            PRESS1: begin
                if (release_ev)
                    state_next = WAIT2;
                else if (!PB_pressed_status)
                    state_next = IDLE;
                else if (timer == LONG_LIM) begin
                    state_next = LONG;
                    long_next  = 1'b1;
                end
            end
            WAIT2: begin
                if (press_ev)
                    state_next = PRESS2;
                else if (timer == GAP_LIM) begin
                    state_next  = IDLE;
                    single_next = 1'b1;
                end
            end
            PRESS2: begin
                if (release_ev) begin
                    state_next  = IDLE;
                    double_next = 1'b1;
                end else if (!PB_pressed_status)
                    state_next = IDLE;
            end
            LONG: begin
                if (release_ev || !PB_pressed_status)
                    state_next = IDLE;
`ifdef PB_GESTURE_AUTO_REPEAT_EN
                else if (timer == REP_LIM)
                    repeat_next = 1'b1;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef PB_GESTURE_AUTO_REPEAT_EN
    assign timer_clr = (state_next != state) | repeat_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            repeat_pulse <= 1'b0;
        else
            repeat_pulse <= repeat_next;
    end
`else
    assign timer_clr    = (state_next != state);
    assign repeat_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            timer        <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            single_click <= single_next;
            double_click <= double_next;
            long_press   <= long_next;
            busy         <= (state_next != IDLE);
            if (timer_clr)
                timer <= '0;
            else if (timer != '1)
                timer <= timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_pb_gesture_decoder.sv
// tb/tb_pb_gesture_decoder.sv - directed and randomized checks of pb_gesture_decoder against a timestamp model
module tb_pb_gesture_decoder;

    localparam int LONG   = 20;
    localparam int GAP    = 10;
    localparam int REPEAT = 5;
`ifdef PB_GESTURE_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    localparam int G_IDLE = 0, G_HELD1 = 1, G_GAP = 2, G_HELD2 = 3, G_LONG = 4;

    logic clk;
    logic reset;
    logic status, ppulse, rpulse;
    logic single_click, double_click, long_press, repeat_pulse, busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;

    int phase = G_IDLE;
    int press_cyc, rel_cyc, mark_cyc;

    int n_single, last_single, n_double, last_double, n_long, last_long;
    int n_repeat, first_repeat, last_repeat, n_busy, busy_first, busy_last;

    pb_gesture_decoder #(
        .LONG_CYCLES  (LONG),
        .GAP_CYCLES   (GAP),
        .REPEAT_CYCLES(REPEAT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .PB_pressed_status(status),
        .PB_pressed_pulse (ppulse),
        .PB_released_pulse(rpulse),
        .single_click     (single_click),
        .double_click     (double_click),
        .long_press       (long_press),
        .repeat_pulse     (repeat_pulse),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        t0 = cyc;
        n_single = 0; last_single = -1; n_double = 0; last_double = -1;
        n_long = 0; last_long = -1; n_repeat = 0; first_repeat = -1; last_repeat = -1;
        n_busy = 0; busy_first = -1; busy_last = -1;
    endtask

    // Expected outputs of the next cycle, from the gesture rules expressed as
    // absolute cycle stamps of the press/release edges.
    function automatic logic [4:0] model(input logic p, input logic r, input logic s);
        logic pe, re, sc, dc, lp, rp;
        pe = p & ~r;
        re = r & ~p;
        sc = 0; dc = 0; lp = 0; rp = 0;
        if (!reset) begin
            phase = G_IDLE;
            return 5'b0;
        end
        case (phase)
            G_IDLE:  if (pe) begin phase = G_HELD1; press_cyc = cyc; end
            G_HELD1: begin
                if (re) begin phase = G_GAP; rel_cyc = cyc; end
                else if (!s) phase = G_IDLE;
                else if (cyc + 1 == press_cyc + LONG) begin
                    phase = G_LONG; lp = 1; mark_cyc = cyc + 1;
                end
            end
            G_GAP: begin
                if (pe) phase = G_HELD2;
                else if (cyc + 1 == rel_cyc + GAP) begin phase = G_IDLE; sc = 1; end
            end
            G_HELD2: begin
                if (re) begin phase = G_IDLE; dc = 1; end
                else if (!s) phase = G_IDLE;
            end
            default: begin
                if (re || !s) phase = G_IDLE;
                else if (REP_EN && cyc + 1 == mark_cyc + REPEAT) begin
                    rp = 1; mark_cyc = cyc + 1;
                end
            end
        endcase
        return {sc, dc, lp, rp, logic'(phase != G_IDLE)};
    endfunction

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic p, input logic r, input logic s);
        logic [4:0] exp_v, obs_v;
        ppulse = p; rpulse = r; status = s;
        exp_v = model(p, r, s);
        @(posedge clk);
        #1;
        cyc++;
        obs_v = {single_click, double_click, long_press, repeat_pulse, busy};
        n_cmp++;
        assert (obs_v === exp_v) else begin
            n_err++;
            $error("FAIL cycle%0d outputs observed %b expected %b (sc,dc,lp,rp,busy)",
                   cyc - t0, obs_v, exp_v);
        end
        if (single_click) begin n_single++; last_single = cyc - t0; end
        if (double_click) begin n_double++; last_double = cyc - t0; end
        if (long_press)   begin n_long++;   last_long   = cyc - t0; end
        if (repeat_pulse) begin
            n_repeat++; last_repeat = cyc - t0;
            if (first_repeat < 0) first_repeat = cyc - t0;
        end
        if (busy) begin
            n_busy++; busy_last = cyc - t0;
            if (busy_first < 0) busy_first = cyc - t0;
        end
        @(negedge clk);
    endtask

    task automatic gesture(input int pa, input int ra, input int pa2, input int ra2, input int total);
        clear_obs();
        for (int k = 0; k < total; k++)
            step(k == pa || k == pa2, k == ra || k == ra2,
                 (k >= pa && k < ra) || (pa2 >= 0 && k >= pa2 && k < ra2));
    endtask

    initial begin
        int held, cnt;
        logic p, r, s;

        reset = 1'b0; status = 1'b0; ppulse = 1'b0; rpulse = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", int'({single_click, double_click, long_press, repeat_pulse, busy}), 0);
        reset = 1'b1;
        phase = G_IDLE;

        // single click
        gesture(10, 15, -1, -1, 32);
        chk("single_n", n_single, 1);
        chk("single_cycle", last_single, 25);
        chk("single_busy_first", busy_first, 11);
        chk("single_busy_last", busy_last, 24);
        chk("single_busy_n", n_busy, 14);

        // double click
        gesture(10, 15, 20, 24, 40);
        chk("double_n", n_double, 1);
        chk("double_cycle", last_double, 25);
        chk("double_no_single", n_single, 0);

        // long press held to 60
        gesture(10, 60, -1, -1, 75);
        chk("long_n", n_long, 1);
        chk("long_cycle", last_long, 30);
        chk("long_repeat_n", n_repeat, REP_EN ? 6 : 0);
        chk("long_repeat_first", first_repeat, REP_EN ? 35 : -1);
        chk("long_repeat_last", last_repeat, REP_EN ? 60 : -1);
        chk("long_no_click", n_single + n_double, 0);

        // release on the long threshold cycle
        gesture(10, 29, -1, -1, 50);
        chk("coin_rel_no_long", n_long, 0);
        chk("coin_rel_single", last_single, 39);

        // press on the gap expiry cycle
        gesture(10, 15, 24, 27, 45);
        chk("coin_press_no_single", n_single, 0);
        chk("coin_press_double", last_double, 28);

        // asynchronous reset during the gap
        clear_obs();
        for (int k = 0; k < 18; k++)
            step(k == 10, k == 15, k >= 10 && k < 15);
        #2 reset = 1'b0;
        #1 chk("rst_async_outputs",
               int'({single_click, double_click, long_press, repeat_pulse, busy}), 0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        for (int k = 0; k < 25; k++) step(1'b0, 1'b0, 1'b0);
        chk("rst_no_single", n_single, 0);

        // button held through reset
        reset = 1'b0; status = 1'b1; ppulse = 1'b0; rpulse = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        clear_obs();
        for (int k = 0; k < 32; k++)
            step(k == 8, k == 5 || k == 13, k < 5 || (k >= 8 && k < 13));
        chk("held_busy_first", busy_first, 9);
        chk("held_single_n", n_single, 1);
        chk("held_single_cycle", last_single, 23);

        // randomized button activity with occasional glitches
        clear_obs();
        held = 0; cnt = 5;
        for (int i = 0; i < 1500; i++) begin
            p = 1'b0; r = 1'b0;
            if (cnt == 0) begin
                held = held ^ 1;
                if (held != 0) p = 1'b1; else r = 1'b1;
                cnt = (held != 0) ? int'($urandom_range(1, 26)) : int'($urandom_range(1, 13));
            end else begin
                cnt--;
            end
            s = (held != 0);
            if ($urandom_range(0, 47) == 0) begin p = 1'b1; r = 1'b1; end
            if (s && !p && $urandom_range(0, 79) == 0) s = 1'b0;
            step(p, r, s);
        end
        for (int k = 0; k < 40; k++) step(1'b0, 1'b0, 1'b0);
        chk("random_drained_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pb_gesture_decoder.md
# pb_gesture_decoder

Classifies debounced push-button activity into single-click, double-click and long-press events. Sits directly downstream of the push-button debouncer, consuming its `PB_pressed_status`, `PB_pressed_pulse` and `PB_released_pulse` outputs. Emits one-cycle event pulses to the lab's control FSMs. All timing is counted in `clk` cycles.

## Interface
- `LONG_CYCLES`, default 50_000_000: hold duration that qualifies as a long press; legal values ≥ 2.
- `GAP_CYCLES`, default 25_000_000: maximum release-to-press gap for a double click; legal values ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period. Used only with `AUTO_REPEAT_EN`; legal values ≥ 2.
- `clk` input 1: single system clock.
- `reset` input 1: asynchronous, active-low reset (0 = reset).
- `PB_pressed_status` input 1: debounced level, high while the button is held.
- `PB_pressed_pulse` input 1: one-cycle press edge from the debouncer.
- `PB_released_pulse` input 1: one-cycle release edge from the debouncer.
- `single_click` output 1: one-cycle pulse for a completed single click.
- `double_click` output 1: one-cycle pulse for a completed double click.
- `long_press` output 1: one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat_pulse` output 1: periodic pulse while a long press is held. Tied to 0 without `AUTO_REPEAT_EN`.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, PRESS1, WAIT2, PRESS2, LONG.
- **Timer:** one shared counter, width $clog2(max(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES))+1. It clears to 0 on every state change, increments by 1 each cycle while the state is unchanged, and never wraps.
- **Input filtering:** if `PB_pressed_pulse` and `PB_released_pulse` are both high in one cycle, the cycle is treated as having no event.
- **IDLE:**
  - Press pulse → PRESS1.
  - Release pulse is ignored. This covers a button held through reset.
- **PRESS1:**
  - Release pulse → WAIT2.
  - Otherwise, when the timer reaches `LONG_CYCLES`-1 → LONG, and `long_press` fires.
  - If release and the threshold coincide, release wins: go to WAIT2, no `long_press`.
- **WAIT2:**
  - Press pulse → PRESS2.
  - Otherwise, when the timer reaches `GAP_CYCLES`-1 → IDLE, and `single_click` fires.
  - If press and expiry coincide, press wins: go to PRESS2, no `single_click`.
- **PRESS2:**
  - Release pulse → IDLE, and `double_click` fires.
  - Hold duration is not checked.
- **LONG:**
  - Release pulse, or `PB_pressed_status` = 0 in any cycle → IDLE.
  - No click event is produced on exit.
- **Recovery:** in PRESS1 or PRESS2, if `PB_pressed_status` = 0 with no release pulse (upstream reset), go to IDLE without any event.
- **Exclusivity:** at most one of `single_click`, `double_click`, `long_press` and `repeat_pulse` is high in any cycle.

## Timing
- All outputs are registered. Reset value of every output is 0. Reset forces IDLE and clears the timer, immediately and asynchronously, including mid-gesture.
- Let N be the cycle in which the first press pulse is high.
- **long_press:** high exactly in cycle N+LONG_CYCLES, if no release pulse occurred in cycles N+1 … N+LONG_CYCLES-1.
- **single_click:** let R be the release-pulse cycle. `single_click` is high exactly in cycle R+GAP_CYCLES, if no press pulse occurred in R+1 … R+GAP_CYCLES-1.
- **double_click:** high in the cycle after the second release pulse.
- **busy:** rises in cycle N+1. Falls in the cycle after the IDLE transition, which is the same cycle the final event pulse is high.
- **Back-to-back gestures:** a new press pulse is accepted in the first cycle that `busy` is low.

## Configuration
- Macro: `PB_GESTURE_AUTO_REPEAT_EN`.
- **Defined:**
  - While in LONG, `repeat_pulse` fires every `REPEAT_CYCLES` cycles.
  - The first repeat is in cycle N+LONG_CYCLES+REPEAT_CYCLES; the timer restarts at 0 after each repeat.
  - Repeats stop the cycle after the state leaves LONG.
- **Undefined:**
  - `repeat_pulse` is a constant 0, and no repeat logic is synthesized.
  - LONG only waits for release.

## Test plan
Bench parameters: LONG=20, GAP=10, REPEAT=5.

- **Single click:** press at cycle 10, release at 15 → `single_click` high only in cycle 25; `busy` high in cycles 11–24.
- **Double click:** press 10, release 15, press 20, release 24 → `double_click` high only in cycle 25; no `single_click`.
- **Long press with repeat:** press 10, hold to 60 → `long_press` at 30.
  - With the macro: `repeat_pulse` at 35, 40, 45, 50, 55, 60; the release at 60 ends the repeats after that.
  - Without the macro: `repeat_pulse` is never high.
- **Coincidence:** release pulse exactly at cycle 29 (long threshold) → no `long_press`, `single_click` at 39. Press pulse exactly at gap expiry → PRESS2, no `single_click`.
- **Reset mid-gesture:** `reset`=0 asynchronously during WAIT2 → all outputs 0 immediately. After reset releases, no `single_click` is ever emitted for that gesture.
- **Held through reset:** status=1 at reset release, release pulse at 5, press pulse at 8 → release ignored, PRESS1 entered, normal single click follows.
